// File: rtl/rts_session_controller.sv
// BIST session sequencer: runs PRPG load, scan shift, capture and MISR
// compaction for a programmable number of rounds, then strobes the signature compare.
module rts_session_controller #(
   parameter int SHIFT_SIZE     = 43,
   parameter int CAPTURE_CYCLES = 1,
   parameter int ROUND_W        = 16
) (
   input  logic               clk,
   input  logic               rstIn,
   input  logic               start,
   input  logic               abort,
   input  logic [ROUND_W-1:0] numRounds,
   input  logic               sigMatch,
   output logic               NbarT,
   output logic               rstOut,
   output logic               PRPG_En,
   output logic               SRSG_En,
   output logic               SISA_En,
   output logic               MISR_En,
   output logic               sigCmp_En,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [ROUND_W-1:0] roundCount
);

   localparam int SHIFT_W = $clog2(SHIFT_SIZE + 1);
   localparam int CAP_W   = $clog2(CAPTURE_CYCLES + 1);
   localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(SHIFT_SIZE - 1);
   localparam logic [CAP_W-1:0]   CAP_LAST   = CAP_W'(CAPTURE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RESET, S_GEN_DATA, S_SHIFT, S_CAPTURE, S_GEN_SIG, S_COMPARE, S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [SHIFT_W-1:0]   r_shift_cnt;
   logic [CAP_W-1:0]     r_cap_cnt;
   logic [ROUND_W-1:0]   r_rounds;
   logic [ROUND_W-1:0]   r_round_count;
   logic                 r_pass;
   logic                 w_start_ok;
   logic [ROUND_W:0]     w_round_inc;
   logic                 w_more_rounds;

   assign w_start_ok    = start & ~abort;
   // One extra bit keeps the last-round test exact even at the top of the count range.
   assign w_round_inc   = {1'b0, r_round_count} + (ROUND_W + 1)'(1);
   assign w_more_rounds = w_round_inc < {1'b0, r_rounds};

   assign pass       = r_pass;
   assign roundCount = r_round_count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rstIn) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: every output and the next state get a default first, so no path
   // through the case leaves a variable unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      NbarT        = 1'b0;
      rstOut       = 1'b0;
      PRPG_En      = 1'b0;
      SRSG_En      = 1'b0;
      SISA_En      = 1'b0;
      MISR_En      = 1'b0;
      sigCmp_En    = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_next_state = S_RESET;
         end
         S_RESET: begin
            rstOut       = 1'b1;
            NbarT        = 1'b1;
            busy         = 1'b1;
            w_next_state = S_GEN_DATA;
         end
         S_GEN_DATA: begin
            PRPG_En      = 1'b1;
            busy         = 1'b1;
            w_next_state = S_SHIFT;
         end
         S_SHIFT: begin
            SRSG_En = 1'b1;
            SISA_En = 1'b1;
            NbarT   = 1'b1;
            busy    = 1'b1;
            if (r_shift_cnt == SHIFT_LAST) w_next_state = S_CAPTURE;
         end
         S_CAPTURE: begin
            busy = 1'b1;
            if (r_cap_cnt == CAP_LAST) w_next_state = S_GEN_SIG;
         end
         S_GEN_SIG: begin
            MISR_En      = 1'b1;
            busy         = 1'b1;
            w_next_state = w_more_rounds ? S_GEN_DATA : S_COMPARE;
         end
         S_COMPARE: begin
            sigCmp_En    = 1'b1;
            busy         = 1'b1;
            w_next_state = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (w_start_ok) w_next_state = S_RESET;
         end
         default: w_next_state = S_IDLE;
      endcase

      if (abort) w_next_state = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rstIn) begin
         r_shift_cnt   <= '0;
         r_cap_cnt     <= '0;
         r_rounds      <= '0;
         r_round_count <= '0;
         r_pass        <= 1'b0;
      end else if (abort) begin
         r_shift_cnt   <= '0;
         r_cap_cnt     <= '0;
         r_round_count <= '0;
         r_pass        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  // A request for zero rounds still runs one full round.
                  r_rounds      <= (numRounds == '0) ? ROUND_W'(1) : numRounds;
                  r_round_count <= '0;
                  r_pass        <= 1'b0;
               end
            end
            S_GEN_DATA: begin
               r_shift_cnt <= '0;
               r_cap_cnt   <= '0;
            end
            S_SHIFT:   r_shift_cnt   <= r_shift_cnt + SHIFT_W'(1);
            S_CAPTURE: r_cap_cnt     <= r_cap_cnt + CAP_W'(1);
            S_GEN_SIG: r_round_count <= w_round_inc[ROUND_W-1:0];
            S_COMPARE: r_pass        <= sigMatch;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rts_session_controller.sv
// Randomized scoreboard bench for rts_session_controller: the driver queues the
// expected session summary, the monitor measures each completed session against it.
module tb_rts_session_controller;

   localparam int S      = 4;
   localparam int C      = 1;
   localparam int RW     = 16;
   localparam int PERIOD = S + C + 2;

   logic          clk = 1'b0;
   logic          rstIn;
   logic          start;
   logic          abort;
   logic [RW-1:0] numRounds;
   logic          sigMatch;
   logic          NbarT, rstOut, PRPG_En, SRSG_En, SISA_En, MISR_En, sigCmp_En;
   logic          busy, done, pass;
   logic [RW-1:0] roundCount;

   rts_session_controller #(
      .SHIFT_SIZE    (S),
      .CAPTURE_CYCLES(C),
      .ROUND_W       (RW)
   ) dut (
      .clk       (clk),
      .rstIn     (rstIn),
      .start     (start),
      .abort     (abort),
      .numRounds (numRounds),
      .sigMatch  (sigMatch),
      .NbarT     (NbarT),
      .rstOut    (rstOut),
      .PRPG_En   (PRPG_En),
      .SRSG_En   (SRSG_En),
      .SISA_En   (SISA_En),
      .MISR_En   (MISR_En),
      .sigCmp_En (sigCmp_En),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .roundCount(roundCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lat;
      int rounds;
      bit pass;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [9:0] outs();
      return {NbarT, rstOut, PRPG_En, SRSG_En, SISA_En, MISR_En, sigCmp_En, busy, done, pass};
   endfunction

   task automatic check_idle(input string name);
      check({name, "_outputs"}, outs(), 0);
      check({name, "_roundCount"}, roundCount, 0);
   endtask

   function automatic int eff_rounds(input int n);
      return (n == 0) ? 1 : n;
   endfunction

   task automatic wait_done(input int budget);
      int i = 0;
      while (!done && i < budget) begin
         @(negedge clk);
         i++;
      end
      check("done_within_budget", done, 1);
   endtask

   // extra_at > 0 re-pulses start (with other rounds) that many edges after acceptance.
   task automatic run_session(input int n, input bit sig, input int extra_at);
      exp_t e;
      e.rounds = eff_rounds(n);
      e.lat    = e.rounds * PERIOD + 2;
      e.pass   = sig;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b1; numRounds = RW'(n); sigMatch = sig;
      @(negedge clk);
      start = 1'b0; numRounds = RW'($urandom_range(0, 9));
      check("accept_busy", busy, 1);
      check("accept_done_low", done, 0);
      if (extra_at > 0) begin
         repeat (extra_at - 1) @(negedge clk);
         start = 1'b1; numRounds = RW'(n + 2);
         @(negedge clk);
         start = 1'b0;
      end
      wait_done(e.lat + 4);
   endtask

   task automatic abort_session(input int n, input int a);
      @(negedge clk);
      start = 1'b1; numRounds = RW'(n);
      @(negedge clk);
      start = 1'b0;
      repeat (a - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle("abort_busy");
   endtask

   // Monitor: counts enable activity per session and scores each completed one.
   int m_ncyc = 0, m_t0 = 0;
   bit m_pb = 1'b0, m_pd = 1'b0;
   int m_rst, m_prpg, m_srsg, m_sisa, m_misr, m_cmp, m_nbt;

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         m_ncyc++;
         if (busy && !m_pb) begin
            m_t0 = m_ncyc;
            m_rst = 0; m_prpg = 0; m_srsg = 0; m_sisa = 0; m_misr = 0; m_cmp = 0; m_nbt = 0;
         end
         m_rst  += int'(rstOut);
         m_prpg += int'(PRPG_En);
         m_srsg += int'(SRSG_En);
         m_sisa += int'(SISA_En);
         m_misr += int'(MISR_En);
         m_cmp  += int'(sigCmp_En);
         m_nbt  += int'(NbarT);
         if (done && !m_pd) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", done, 0);
            end else begin
               e = sb_q.pop_front();
               check("done_latency", m_ncyc - m_t0, e.lat);
               check("roundCount", roundCount, e.rounds);
               check("pass", pass, e.pass);
               check("rstOut_pulses", m_rst, 1);
               check("PRPG_pulses", m_prpg, e.rounds);
               check("SRSG_cycles", m_srsg, e.rounds * S);
               check("SISA_cycles", m_sisa, e.rounds * S);
               check("MISR_pulses", m_misr, e.rounds);
               check("sigCmp_pulses", m_cmp, 1);
               check("NbarT_cycles", m_nbt, 1 + e.rounds * S);
               check("busy_in_done", busy, 0);
            end
         end
         m_pb = busy;
         m_pd = done;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      int  n, L, mode, gap;
      bit  sig, found;
      rstIn = 1'b1; start = 1'b0; abort = 1'b0; sigMatch = 1'b0; numRounds = '0;
      repeat (2) @(negedge clk);
      rstIn = 1'b0;
      @(negedge clk);
      check_idle("reset");
      repeat (10) @(negedge clk);
      check_idle("no_start_idle");

      run_session(2, 1'b1, 0);
      run_session(2, 1'b0, 0);
      run_session(2, 1'b1, 0);
      run_session(0, 1'b1, 0);

      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle("abort_in_done");

      abort_session(2, 5);

      @(negedge clk);
      start = 1'b1; abort = 1'b1; numRounds = RW'(3);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check_idle("start_abort_idle");
      @(negedge clk);
      check("stay_idle_busy", busy, 0);

      run_session(3, 1'b1, 6);

      @(negedge clk);
      start = 1'b1; numRounds = RW'(3);
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (roundCount == RW'(1) && busy && !NbarT && !PRPG_En && !MISR_En && !sigCmp_En && !rstOut)
            found = 1'b1;
         else
            @(negedge clk);
      end
      check("capture_round2_reached", found, 1);
      rstIn = 1'b1;
      @(negedge clk);
      rstIn = 1'b0;
      check_idle("rst_mid_capture");

      for (int it = 0; it < 14; it++) begin
         n    = $urandom_range(0, 5);
         sig  = 1'($urandom_range(0, 1));
         L    = eff_rounds(n) * PERIOD + 2;
         mode = $urandom_range(0, 3);
         if (mode == 0)      abort_session(n, $urandom_range(1, L));
         else if (mode == 1) run_session(n, sig, $urandom_range(1, L - 1));
         else                run_session(n, sig, 0);
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
